seq_tx_11011: RTL and testbench

Serial pattern transmitter that drives the single-bit `signal` line consumed by the non-overlapping 11011 Moore detector. On a start request it emits a fixed WIDTH-bit pattern MSB-first, a programmable number of times, with a programmable run of idle zeros between frames. It serves as the stimulus source and loop-back partner for the detector family: a detector fed by this block must report exactly `count` detections per request.

---
 rtl/seq_tx_11011_pkg.sv | 12 +
 rtl/seq_tx_11011_shreg.sv | 20 ++
 rtl/seq_tx_11011.sv | 92 +++++++++
 tb/tb_seq_tx_11011.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/seq_tx_11011_pkg.sv
// seq_tx_11011_pkg: shared state encoding and default frame constants for the 11011 transmitter/detector family
package seq_tx_11011_pkg;
  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    DONE
  } state_t;
  localparam int DEF_WIDTH = 5;
  localparam logic [DEF_WIDTH-1:0] DEF_PATTERN = 5'b11011;
  localparam int DEF_CNT_W = 4;
endpackage

// File: rtl/seq_tx_11011_shreg.sv
// pat_shreg: parallel-load MSB-first shift register holding the frame pattern
module pat_shreg #(
  parameter int WIDTH = 5,
  parameter logic [WIDTH-1:0] PATTERN = 5'b11011
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic shift,
  output logic msb
);
  logic [WIDTH-1:0] q;
  // load wins over shift so a frame restart always begins at the pattern MSB
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else if (load) q <= PATTERN;
    else if (shift) q <= {q[WIDTH-2:0], 1'b0};
  end
  assign msb = q[WIDTH-1];
endmodule

// File: rtl/seq_tx_11011.sv
// seq_tx_11011: repeats a fixed serial frame count times with gap idle zeros between frames
module seq_tx_11011
  import seq_tx_11011_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] PATTERN = DEF_PATTERN,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] count,
  input  logic [CNT_W-1:0] gap,
  output logic             signal,
  output logic             busy,
  output logic             frame_done,
  output logic             done
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);
  state_t state, nstate;
  logic [CNT_W-1:0] frames_left, gap_reg, gap_cnt;
  logic [IDX_W-1:0] idx;
  logic accept, last_bit, load, shift, msb;
  pat_shreg #(
    .WIDTH(WIDTH),
    .PATTERN(PATTERN)
  ) u_shreg (
    .clk(clk),
    .rst(rst),
    .load(load),
    .shift(shift),
    .msb(msb)
  );
  // request qualification and shift-register control derived from the FSM
  always_comb begin
    accept = start && (count != '0);
    last_bit = idx == '0;
    load = (nstate == SEND) && ((state != SEND) || last_bit);
    shift = state == SEND;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nstate;
  end
  // next state; abort overrides every transition
  always_comb begin
    nstate = state;
    case (state)
      IDLE: nstate = accept ? SEND : IDLE;
      SEND: nstate = !last_bit ? SEND :
                     (frames_left == CNT_W'(1)) ? DONE :
                     (gap_reg == '0) ? SEND : GAP;
      GAP:  nstate = (gap_cnt <= CNT_W'(1)) ? SEND : GAP;
      DONE: nstate = IDLE;
      default: nstate = IDLE;
    endcase
    if (abort) nstate = IDLE;
  end
  // frame, gap and bit counters; all saturate at zero instead of wrapping
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      frames_left <= '0;
      gap_reg <= '0;
      gap_cnt <= '0;
      idx <= '0;
    end else if (state == IDLE) begin
      if (accept) begin
        frames_left <= count;
        gap_reg <= gap;
        idx <= IDX_TOP;
      end
    end else if (state == SEND) begin
      idx <= last_bit ? IDX_TOP : idx - 1'b1;
      if (last_bit) begin
        frames_left <= (frames_left == '0) ? '0 : frames_left - 1'b1;
        gap_cnt <= gap_reg;
      end
    end else if (state == GAP) begin
      gap_cnt <= (gap_cnt == '0) ? '0 : gap_cnt - 1'b1;
    end
  end
  // Moore outputs decoded purely from registered state
  always_comb begin
    signal = (state == SEND) && msb;
    busy = state != IDLE;
    frame_done = (state == SEND) && last_bit;
    done = state == DONE;
  end
endmodule

// File: tb/tb_seq_tx_11011.sv
// tb_seq_tx_11011: scoreboard bench expanding each request into its expected waveform
module tb_seq_tx_11011;
  logic clk = 0, rst = 1, start = 0, abort = 0;
  logic [3:0] count = 0, gap = 0;
  logic signal, busy, frame_done, done;
  always #5 clk = ~clk;
  seq_tx_11011 dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .count(count),
    .gap(gap),
    .signal(signal),
    .busy(busy),
    .frame_done(frame_done),
    .done(done)
  );
  typedef struct {
    logic [3:0] w;
    int det;
  } exp_t;
  exp_t sb[$];
  exp_t plan[$];
  exp_t m;
  logic [4:0] pat = 5'b11011;
  logic cur_busy = 0;
  int vectors = 0, miscompares = 0;
  int det = 0, bits = 0;
  logic [4:0] win = 0;
  task automatic build(input int c, input int g);
    exp_t e;
    e.det = -1;
    for (int f = 0; f < c; f++) begin
      for (int b = 4; b >= 0; b--) begin
        e.w = {pat[b], 1'b1, b == 0, 1'b0};
        plan.push_back(e);
      end
      if (f < c - 1)
        for (int k = 0; k < g; k++) begin
          e.w = 4'b0100;
          plan.push_back(e);
        end
    end
    e.w = 4'b0101;
    e.det = c;
    plan.push_back(e);
  endtask
  task automatic step(input logic r, input logic s, input logic a, input int c, input int g);
    exp_t e;
    @(negedge clk);
    rst = r;
    start = s;
    abort = a;
    count = 4'(c);
    gap = 4'(g);
    if (r || a) plan.delete();
    else if (!cur_busy && s && count != 0) build(int'(count), int'(gap));
    if (plan.size() > 0) e = plan.pop_front();
    else begin
      e.w = 4'b0000;
      e.det = -1;
    end
    cur_busy = e.w[2];
    sb.push_back(e);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask
  always begin
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      m = sb.pop_front();
      vectors++;
      if ({signal, busy, frame_done, done} !== m.w) begin
        miscompares++;
        $display("FAIL outputs t=%0t sig/busy/fd/done got %b want %b", $time,
                 {signal, busy, frame_done, done}, m.w);
      end
      if (!busy) begin
        det = 0;
        bits = 0;
        win = 0;
      end else begin
        win = {win[3:0], signal};
        bits++;
        if (bits >= 5 && win == pat) begin
          det++;
          bits = 0;
          win = 0;
        end
      end
      if (m.det >= 0) begin
        vectors++;
        if (det != m.det) begin
          miscompares++;
          $display("FAIL loopback t=%0t detections got %0d want %0d", $time, det, m.det);
        end
      end
    end
  end
  initial begin
    repeat (3) step(1, 0, 0, 0, 0);
    idle(2);
    step(0, 1, 0, 1, 3);
    idle(10);
    step(0, 1, 0, 3, 2);
    idle(6);
    step(0, 1, 0, 1, 0);
    idle(20);
    step(0, 1, 0, 2, 0);
    idle(14);
    step(0, 1, 0, 0, 5);
    idle(3);
    step(0, 1, 0, 3, 1);
    idle(8);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 1, 2);
    idle(10);
    step(0, 1, 0, 2, 1);
    idle(3);
    repeat (2) step(1, 0, 0, 0, 0);
    idle(3);
    step(0, 1, 1, 3, 0);
    idle(3);
    for (int i = 0; i < 1500; i++)
      step($urandom % 200 == 0, $urandom % 6 == 0, $urandom % 60 == 0,
           $urandom_range(0, 15), $urandom_range(0, 15));
    idle(4);
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending got %0d want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
